data_mem_ctrl: RTL

Parametrised, multi-cycle data memory controller that replaces the single-cycle data memory beside the pipelined ARM core. It accepts one load/store per transaction, models a configurable number of wait states, and raises `Stall` so the pipeline freezes until the access completes. It adds byte-lane writes for STRB/STRH, a registered read port, and out-of-range address detection.

---
 rtl/data_mem_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory controller: accepts one load/store, waits WAIT cycles
// with Stall raised, then completes in a single DONE cycle with byte-lane writes.
module data_mem_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 64,
    parameter int WAIT   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DATA_W/8-1:0]   ByteEn,
    input  logic [ADDR_W-1:0]     DataAdr,
    input  logic [DATA_W-1:0]     WriteData,
    output logic [DATA_W-1:0]     ReadData,
    output logic                  Stall,
    output logic                  RdValid,
    output logic                  AddrErr
);

    localparam int LANES     = DATA_W / 8;
    localparam int LANE_BITS = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int CW        = $clog2(WAIT + 1);
    localparam int IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [CW-1:0]     CNT_LOAD = CW'(WAIT - 1);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state, state_next;
    logic [CW-1:0]       cnt, cnt_next;
    logic [ADDR_W-1:0]   adr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [LANES-1:0]    ben_q;
    logic                wr_q;

    logic                req;
    logic                fire;
    logic [ADDR_W-1:0]   acc_adr;
    logic [DATA_W-1:0]   acc_wdata;
    logic [LANES-1:0]    acc_ben;
    logic                acc_wr;
    logic [ADDR_W-1:0]   word_idx;
    logic                in_range;
    logic [IW-1:0]       mem_idx;

    logic [DATA_W-1:0]   mem [DEPTH];

    assign req = MemRead | MemWrite;

    // With WAIT=1 the access fires on the accept edge, so it must use the live
    // inputs; otherwise it uses the copy latched at accept.
    assign acc_adr   = (state == IDLE) ? DataAdr   : adr_q;
    assign acc_wdata = (state == IDLE) ? WriteData : wdata_q;
    assign acc_ben   = (state == IDLE) ? ByteEn    : ben_q;
    assign acc_wr    = (state == IDLE) ? MemWrite  : wr_q;

    assign word_idx = acc_adr >> LANE_BITS;
    assign in_range = (word_idx < DEPTH_A);
    assign mem_idx  = word_idx[IW-1:0];

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        fire       = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (CNT_LOAD == '0) begin
                        state_next = DONE;
                        fire       = 1'b1;
                    end else begin
                        state_next = BUSY;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (cnt > CNT_ONE) begin
                    cnt_next = cnt - CNT_ONE;
                end else begin
                    cnt_next   = '0;
                    state_next = DONE;
                    fire       = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            adr_q    <= '0;
            wdata_q  <= '0;
            ben_q    <= '0;
            wr_q     <= 1'b0;
            ReadData <= '0;
            RdValid  <= 1'b0;
            AddrErr  <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            RdValid <= fire & ~acc_wr;
            AddrErr <= fire & ~in_range;
            if (state == IDLE && req) begin
                adr_q   <= DataAdr;
                wdata_q <= WriteData;
                ben_q   <= ByteEn;
                wr_q    <= MemWrite;
            end
            if (fire && !acc_wr) begin
                ReadData <= in_range ? mem[mem_idx] : '0;
            end
        end
    end

    // Storage has no reset; gating on reset drops a write racing a reset assertion.
    always_ff @(posedge clk) begin
        if (reset && fire && acc_wr && in_range) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (acc_ben[i]) begin
                    mem[mem_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign Stall = reset & (((state == IDLE) & req) | (state == BUSY));

endmodule
